// File: rtl/hilo_pkg.sv
// hilo_pkg: opcodes, FSM states and default width shared by the HI/LO register block.
package hilo_pkg;
    localparam int HILO_W = 32;
    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_WR_HI   = 3'd1,
        OP_WR_LO   = 3'd2,
        OP_WR_BOTH = 3'd3,
        OP_MADD    = 3'd4,
        OP_MADDU   = 3'd5,
        OP_MSUB    = 3'd6,
        OP_MSUBU   = 3'd7
    } op_e;
    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_e;
endpackage

// File: rtl/hilo_mul.sv
// hilo_mul: combinational signed/unsigned DATA_W x DATA_W -> 2*DATA_W multiplier.
module hilo_mul
    import hilo_pkg::*;
#(
    parameter int DATA_W = HILO_W
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                sgn,
    output logic [2*DATA_W-1:0] p
);
    logic [2*DATA_W-1:0] ax, bx;
    // Extending to full width first makes the truncated product correct for both signednesses.
    assign ax = {{DATA_W{sgn & a[DATA_W-1]}}, a};
    assign bx = {{DATA_W{sgn & b[DATA_W-1]}}, b};
    assign p  = ax * bx;
endmodule

// File: rtl/hilo_acc_reg.sv
// hilo_acc_reg: HI/LO special registers with independent writes and a two-edge
// multiply-accumulate/subtract path, valid/ready handshake and flush.
module hilo_acc_reg
    import hilo_pkg::*;
#(
    parameter int                DATA_W  = HILO_W,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              flush,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              busy
);
    state_e              state;
    logic [2*DATA_W-1:0] prod, prod_q, acc;
    logic                sub_q, accept, wr_hi, wr_lo, is_acc, is_signed, is_sub;

    assign busy      = (state == ACC);
    assign in_ready  = ~busy;
    assign accept    = in_valid & in_ready & ~flush;
    assign wr_hi     = (op == OP_WR_HI) || (op == OP_WR_BOTH);
    assign wr_lo     = (op == OP_WR_LO) || (op == OP_WR_BOTH);
    assign is_acc    = op[2];
    assign is_signed = (op == OP_MADD) || (op == OP_MSUB);
    assign is_sub    = (op == OP_MSUB) || (op == OP_MSUBU);
    assign acc       = sub_q ? {hi_o, lo_o} - prod_q : {hi_o, lo_o} + prod_q;

    hilo_mul #(.DATA_W(DATA_W)) u_mul (
        .a   (hi_i),
        .b   (lo_i),
        .sgn (is_signed),
        .p   (prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            hi_o   <= RST_VAL;
            lo_o   <= RST_VAL;
            prod_q <= '0;
            sub_q  <= 1'b0;
        end else if (state == ACC) begin
            // Flush cancels the pending commit; HI/LO keep pre-accumulate values.
            state <= IDLE;
            if (!flush) {hi_o, lo_o} <= acc;
        end else if (accept) begin
            hi_o <= wr_hi ? hi_i : hi_o;
            lo_o <= wr_lo ? lo_i : lo_o;
            if (is_acc) begin
                state  <= ACC;
                prod_q <= prod;
                sub_q  <= is_sub;
            end
        end
    end
endmodule

// File: tb/tb_hilo_acc_reg.sv
// tb_hilo_acc_reg: scoreboard bench; a behavioural HI/LO model pushes expected
// {HI,LO} per accepted op and each scenario pops and compares on commit.
module tb_hilo_acc_reg;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] hi_i = '0, lo_i = '0;
    logic        flush = 1'b0;
    logic [31:0] hi_o, lo_o;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] model = '0;
    logic [63:0] exp_q[$];
    logic [63:0] expv;

    hilo_acc_reg dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .hi_i     (hi_i),
        .lo_i     (lo_i),
        .flush    (flush),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [63:0] next_val(input logic [2:0] o, input logic [31:0] h, input logic [31:0] l,
                                             input logic [63:0] cur);
        logic signed [63:0] sp;
        logic [63:0]        up;
        sp = $signed(h) * $signed(l);
        up = {32'd0, h} * {32'd0, l};
        case (o)
            OP_WR_HI:   next_val = {h, cur[31:0]};
            OP_WR_LO:   next_val = {cur[63:32], l};
            OP_WR_BOTH: next_val = {h, l};
            OP_MADD:    next_val = cur + sp;
            OP_MADDU:   next_val = cur + up;
            OP_MSUB:    next_val = cur - sp;
            OP_MSUBU:   next_val = cur - up;
            default:    next_val = cur;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        in_valid = 1'b1; op = o; hi_i = h; lo_i = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = OP_NOP;
    endtask

    // Drives one op, pushes the model result, waits for its commit, then pops and compares.
    task automatic run_op(input logic [2:0] o, input logic [31:0] h, input logic [31:0] l, input string name);
        issue(o, h, l);
        model = next_val(o, h, l, model);
        exp_q.push_back(model);
        if (o[2]) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_in_acc: busy=%b in_ready=%b required busy=1 in_ready=0", name, busy, in_ready);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_after: busy=%b in_ready=%b required busy=0 in_ready=1", name, busy, in_ready);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty: got empty queue required an entry", name);
        end else begin
            expv = exp_q.pop_front();
            if ({hi_o, lo_o} !== expv) begin
                errors++;
                $display("FAIL %s hilo: got %h required %h", name, {hi_o, lo_o}, expv);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({hi_o, lo_o} !== 64'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: hilo=%h busy=%b in_ready=%b required 0 0 1", {hi_o, lo_o}, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_writes();
        run_op(OP_WR_BOTH, 32'h12345678, 32'h9ABCDEF0, "wr_both");
        checks++;
        if ({hi_o, lo_o} !== 64'h12345678_9ABCDEF0) begin
            errors++;
            $display("FAIL wr_both_const: got %h required 123456789abcdef0", {hi_o, lo_o});
        end
        run_op(OP_WR_HI, 32'hFFFFFFFF, 32'h0BAD0BAD, "wr_hi");
        checks++;
        if ({hi_o, lo_o} !== 64'hFFFFFFFF_9ABCDEF0) begin
            errors++;
            $display("FAIL wr_hi_const: got %h required ffffffff9abcdef0", {hi_o, lo_o});
        end
        run_op(OP_WR_LO, 32'h0BAD0BAD, 32'h00C0FFEE, "wr_lo");
        run_op(OP_NOP, 32'h11111111, 32'h22222222, "nop");
    endtask

    task automatic test_accumulate();
        run_op(OP_WR_BOTH, 32'd0, 32'd0, "clear0");
        run_op(OP_MADD, 32'hFFFFFFFF, 32'd2, "madd");
        checks++;
        if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFFE) begin
            errors++;
            $display("FAIL madd_const: got %h required fffffffffffffffe", {hi_o, lo_o});
        end
        run_op(OP_WR_BOTH, 32'd0, 32'd0, "clear1");
        run_op(OP_MADDU, 32'hFFFFFFFF, 32'd2, "maddu");
        checks++;
        if ({hi_o, lo_o} !== 64'h00000001_FFFFFFFE) begin
            errors++;
            $display("FAIL maddu_const: got %h required 00000001fffffffe", {hi_o, lo_o});
        end
        run_op(OP_WR_BOTH, 32'd0, 32'd1, "set01");
        run_op(OP_MSUBU, 32'd2, 32'd2, "msubu_wrap");
        checks++;
        if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFFD) begin
            errors++;
            $display("FAIL msubu_const: got %h required fffffffffffffffd", {hi_o, lo_o});
        end
        run_op(OP_MSUB, 32'hFFFFFFFD, 32'd7, "msub");
        run_op(OP_WR_BOTH, 32'hFFFFFFFF, 32'hFFFFFFFF, "set_ones");
        run_op(OP_MADDU, 32'd1, 32'd1, "maddu_wrap");
        checks++;
        if ({hi_o, lo_o} !== 64'd0) begin
            errors++;
            $display("FAIL add_wrap_const: got %h required 0000000000000000", {hi_o, lo_o});
        end
    endtask

    task automatic test_flush();
        run_op(OP_WR_BOTH, 32'h00000011, 32'h00000022, "pre_flush");
        @(negedge clk);
        in_valid = 1'b1; op = OP_WR_BOTH; hi_i = 32'hDEADBEEF; lo_i = 32'hCAFEF00D; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if ({hi_o, lo_o} !== model || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: hilo=%h busy=%b required %h busy=0", {hi_o, lo_o}, busy, model);
        end
        issue(OP_MADD, 32'd3, 32'd4);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if ({hi_o, lo_o} !== model || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_acc: hilo=%h busy=%b in_ready=%b required %h 0 1", {hi_o, lo_o}, busy, in_ready, model);
        end
        run_op(OP_WR_LO, 32'd0, 32'd5, "wr_lo_after_flush");
        checks++;
        if ({hi_o, lo_o} !== 64'h00000011_00000005) begin
            errors++;
            $display("FAIL after_flush_const: got %h required 0000001100000005", {hi_o, lo_o});
        end
    endtask

    task automatic test_busy_ignore();
        issue(OP_MADDU, 32'h10, 32'h10);
        model = next_val(OP_MADDU, 32'h10, 32'h10, model);
        exp_q.push_back(model);
        @(negedge clk);
        in_valid = 1'b1; op = OP_WR_BOTH; hi_i = 32'hDEADBEEF; lo_i = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = OP_NOP;
        checks++;
        expv = exp_q.pop_front();
        if ({hi_o, lo_o} !== expv) begin
            errors++;
            $display("FAIL busy_ignore: got %h required %h", {hi_o, lo_o}, expv);
        end
    endtask

    task automatic test_rst_mid();
        run_op(OP_WR_BOTH, 32'hAA, 32'hBB, "pre_rst");
        issue(OP_MADD, 32'd2, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({hi_o, lo_o} !== 64'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: hilo=%h busy=%b in_ready=%b required 0 0 1", {hi_o, lo_o}, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model = '0;
        checks++;
        if ({hi_o, lo_o} !== 64'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_commit: hilo=%h busy=%b required 0 busy=0", {hi_o, lo_o}, busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            run_op(3'($urandom_range(0, 7)), $urandom, $urandom, "random");
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_writes();
        test_accumulate();
        test_flush();
        test_busy_ignore();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
